// File: rtl/lsq_pkg.sv
// lsq_pkg: shared load/store queue types, widths and SQ age compare.
package lsq_pkg;
    localparam int XLEN        = 32;
    localparam int LQ_DEPTH    = 8;
    localparam int LQ_IDX_LEN  = $clog2(LQ_DEPTH);
    localparam int SQ_IDX_LEN  = 3;
    localparam int ROB_IDX_LEN = 5;

    typedef logic [SQ_IDX_LEN:0] sq_pos_t;

    typedef struct packed {
        logic                   valid;
        logic                   resolved;
        logic                   executed;
        logic [XLEN-1:0]        addr;
        logic [ROB_IDX_LEN-1:0] rob_idx;
        sq_pos_t                sq_pos;
    } lq_entry_t;

    // Store is older than the load when it sits 1..SQ depth slots behind it.
    function automatic logic sq_older(input sq_pos_t ld_pos, input sq_pos_t st_pos);
        sq_pos_t d;
        d = ld_pos - st_pos;
        return (d != '0) && (d <= sq_pos_t'(2 ** SQ_IDX_LEN));
    endfunction
endpackage

// File: rtl/load_queue_ordered_if.sv
// load_queue_ordered_if: dispatch, AGU, store-check and retire signals of the load queue.
interface load_queue_ordered_if;
    import lsq_pkg::*;
    logic                   alloc_valid;
    logic [ROB_IDX_LEN-1:0] alloc_rob_idx;
    sq_pos_t                alloc_sq_pos;
    logic                   alloc_addr_valid;
    logic [XLEN-1:0]        alloc_addr;
    logic [LQ_IDX_LEN-1:0]  alloc_idx;
    logic                   addr_valid;
    logic [LQ_IDX_LEN-1:0]  addr_idx;
    logic [XLEN-1:0]        addr;
    logic                   exec_valid;
    logic [LQ_IDX_LEN-1:0]  exec_idx;
    logic                   st_valid;
    sq_pos_t                st_sq_pos;
    logic [XLEN-1:0]        st_addr;
    logic                   retire;
    logic                   flush;
    logic                   full;
    logic                   empty;
    logic [LQ_IDX_LEN:0]    count;
    logic [XLEN-1:0]        head_addr;
    logic                   head_resolved;
    logic                   viol_valid;
    logic [ROB_IDX_LEN-1:0] viol_rob_idx;
    logic [LQ_IDX_LEN-1:0]  viol_lq_idx;

    modport master (
        output alloc_valid, alloc_rob_idx, alloc_sq_pos, alloc_addr_valid, alloc_addr,
        output addr_valid, addr_idx, addr, exec_valid, exec_idx,
        output st_valid, st_sq_pos, st_addr, retire, flush,
        input  alloc_idx, full, empty, count, head_addr, head_resolved,
        input  viol_valid, viol_rob_idx, viol_lq_idx
    );
    modport slave (
        input  alloc_valid, alloc_rob_idx, alloc_sq_pos, alloc_addr_valid, alloc_addr,
        input  addr_valid, addr_idx, addr, exec_valid, exec_idx,
        input  st_valid, st_sq_pos, st_addr, retire, flush,
        output alloc_idx, full, empty, count, head_addr, head_resolved,
        output viol_valid, viol_rob_idx, viol_lq_idx
    );
endinterface

// File: rtl/lq_oldest_select.sv
// lq_oldest_select: picks the first set match bit scanning from head with wrap.
module lq_oldest_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] match,
    input  logic [W-1:0] head,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [N-1:0] rot;
    logic [W-1:0] pos;

    // Rotate so head lands at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        rot = N'({match, match} >> head);
        pos = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) pos = W'(i);
        found = |match;
        idx   = head + pos;
    end
endmodule

// File: rtl/load_queue_ordered.sv
// load_queue_ordered: in-order load queue with parallel store-to-load ordering check.
module load_queue_ordered
    import lsq_pkg::*;
(
    input logic           clock,
    input logic           reset,
    load_queue_ordered_if.slave lq
);
    lq_entry_t              ent_q [LQ_DEPTH];
    lq_entry_t              ent_d [LQ_DEPTH];
    logic [LQ_IDX_LEN-1:0]  head_q, head_d, tail_q, tail_d, sel_idx;
    logic [LQ_IDX_LEN-1:0]  viol_lq_q, viol_lq_d;
    logic [LQ_IDX_LEN:0]    count_q, count_d;
    logic [ROB_IDX_LEN-1:0] viol_rob_q, viol_rob_d;
    logic                   viol_valid_q, viol_valid_d;
    logic                   do_alloc, do_retire, found;
    logic [LQ_DEPTH-1:0]    match;

    assign lq.full          = count_q == (LQ_IDX_LEN + 1)'(LQ_DEPTH);
    assign lq.empty         = count_q == '0;
    assign lq.count         = count_q;
    assign lq.alloc_idx     = tail_q;
    assign lq.head_addr     = lq.empty ? '0 : ent_q[head_q].addr;
    assign lq.head_resolved = ent_q[head_q].valid && ent_q[head_q].resolved;
    assign lq.viol_valid    = viol_valid_q;
    assign lq.viol_rob_idx  = viol_rob_q;
    assign lq.viol_lq_idx   = viol_lq_q;
    assign do_alloc         = lq.alloc_valid && !lq.full;
    assign do_retire        = lq.retire && !lq.empty;

    // A load issuing this very cycle is treated as executed.
    always_comb begin
        match = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            match[i] = lq.st_valid && ent_q[i].valid && ent_q[i].resolved &&
                       (ent_q[i].executed || (lq.exec_valid && lq.exec_idx == LQ_IDX_LEN'(i))) &&
                       ent_q[i].addr[XLEN-1:2] == lq.st_addr[XLEN-1:2] &&
                       sq_older(ent_q[i].sq_pos, lq.st_sq_pos);
    end

    lq_oldest_select #(.N(LQ_DEPTH)) u_sel (
        .match (match),
        .head  (head_q),
        .found (found),
        .idx   (sel_idx)
    );

    always_comb begin
        ent_d        = ent_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q + (LQ_IDX_LEN + 1)'(do_alloc) - (LQ_IDX_LEN + 1)'(do_retire);
        viol_valid_d = found;
        viol_lq_d    = found ? sel_idx : '0;
        viol_rob_d   = found ? ent_q[sel_idx].rob_idx : '0;
        if (lq.addr_valid && ent_q[lq.addr_idx].valid && !ent_q[lq.addr_idx].resolved) begin
            ent_d[lq.addr_idx].addr     = lq.addr;
            ent_d[lq.addr_idx].resolved = 1'b1;
        end
        if (lq.exec_valid && ent_q[lq.exec_idx].valid && ent_q[lq.exec_idx].resolved)
            ent_d[lq.exec_idx].executed = 1'b1;
        if (do_retire) begin
            ent_d[head_q].valid    = 1'b0;
            ent_d[head_q].resolved = 1'b0;
            ent_d[head_q].executed = 1'b0;
            head_d                 = head_q + 1'b1;
        end
        if (do_alloc) begin
            ent_d[tail_q].valid    = 1'b1;
            ent_d[tail_q].resolved = lq.alloc_addr_valid;
            ent_d[tail_q].executed = 1'b0;
            ent_d[tail_q].rob_idx  = lq.alloc_rob_idx;
            ent_d[tail_q].sq_pos   = lq.alloc_sq_pos;
            if (lq.alloc_addr_valid) ent_d[tail_q].addr = lq.alloc_addr;
            tail_d                 = tail_q + 1'b1;
        end
        if (lq.flush) begin
            for (int i = 0; i < LQ_DEPTH; i++) ent_d[i] = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            viol_valid_d = 1'b0;
            viol_lq_d    = '0;
            viol_rob_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LQ_DEPTH; i++) ent_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            viol_valid_q <= 1'b0;
            viol_lq_q    <= '0;
            viol_rob_q   <= '0;
        end else begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            viol_valid_q <= viol_valid_d;
            viol_lq_q    <= viol_lq_d;
            viol_rob_q   <= viol_rob_d;
        end
    end
endmodule
